// File: rtl/pixel_fifo_pkg.sv
// Shared mode encodings and colour-bar helper for the pixel stream buffer.
package pixel_fifo_pkg;

  localparam logic [1:0] MODE_EXT   = 2'd0;
  localparam logic [1:0] MODE_SOLID = 2'd1;
  localparam logic [1:0] MODE_RAMP  = 2'd2;
  localparam logic [1:0] MODE_BARS  = 2'd3;

  // Bars count down from white (code 7) to black (code 0); channel k follows bit k mod 3.
  function automatic logic bar_bit(input logic [2:0] bar, input int ch);
    logic [2:0] code;
    logic       bit_v;
    code = 3'd7 - bar;
    case (2'(ch % 3))
      2'd0:    bit_v = code[0];
      2'd1:    bit_v = code[1];
      default: bit_v = code[2];
    endcase
    return bit_v;
  endfunction

endpackage

// File: rtl/sync_fifo_core.sv
// Single-clock FIFO: storage, pointers, occupancy, status and a registered read port.
module sync_fifo_core #(
  parameter int WIDTH    = 24,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_req,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_req,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_LVL   = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_LVL   = (AW+1)'(AE_LEVEL);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      level_r;
  logic [WIDTH-1:0] rd_data_r;
  logic             rd_valid_r;
  logic             push_s;
  logic             pop_s;

  // A full FIFO refuses the push even when a pop happens in the same cycle.
  assign push_s = wr_req & ~full;
  assign pop_s  = rd_req & ~empty;

  assign full         = (level_r == FULL_LVL);
  assign empty        = (level_r == {(AW+1){1'b0}});
  assign almost_full  = (level_r >= AF_LVL);
  assign almost_empty = (level_r <= AE_LVL);
  assign level        = level_r;
  assign rd_data      = rd_data_r;
  assign rd_valid     = rd_valid_r;

  // Storage array, left unreset: pointer reset alone discards the contents.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + 1'b1;
        2'b01:   level_r <= level_r - 1'b1;
        default: level_r <= level_r;
      endcase
    end
  end

  // Registered read port: data holds between pops, valid pulses for one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_r  <= {WIDTH{1'b0}};
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= pop_s;
      if (pop_s) begin
        rd_data_r <= mem_r[rd_ptr_r];
      end
    end
  end

endmodule

// File: rtl/pixel_stream_fifo.sv
// Pixel buffer fed by an external writer or an internal test-pattern generator.
module pixel_stream_fifo
  import pixel_fifo_pkg::*;
#(
  parameter int CH_W     = 8,
  parameter int NUM_CH   = 3,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int H_ACTIVE = 640
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 mode,
  input  logic                       gen_en,
  input  logic [NUM_CH*CH_W-1:0]     pattern_color,
  input  logic                       wr_en,
  input  logic [NUM_CH*CH_W-1:0]     din,
  input  logic                       rd_en,
  input  logic                       clear_flags,
  output logic [NUM_CH*CH_W-1:0]     pixel,
  output logic                       pixel_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW  = NUM_CH * CH_W;
  localparam int XW  = $clog2(H_ACTIVE);
  localparam int RUN = H_ACTIVE / 8;
  localparam int RW  = (RUN > 1) ? $clog2(RUN) : 1;
  localparam logic [XW-1:0] X_LAST   = XW'(H_ACTIVE - 1);
  localparam logic [RW-1:0] RUN_LAST = RW'(RUN - 1);

  logic [1:0]    active_mode_r;
  logic [XW-1:0] x_r;
  logic [2:0]    bar_r;
  logic [RW-1:0] run_r;
  logic          overflow_r;
  logic          underflow_r;

  logic          gen_mode_s;
  logic          gen_push_s;
  logic          push_req_s;
  logic [PW-1:0] push_data_s;
  logic [CH_W-1:0] ramp_ch_s;
  logic [PW-1:0] bars_pix_s;
  logic          full_s;
  logic          empty_s;
  logic          ovf_set_s;
  logic          unf_set_s;

  assign gen_mode_s = (active_mode_r != MODE_EXT);
  assign gen_push_s = gen_mode_s & gen_en & ~full_s;

  generate
    if (CH_W > XW) begin : g_ramp_ext
      assign ramp_ch_s = {{(CH_W-XW){1'b0}}, x_r};
    end else begin : g_ramp_trunc
      assign ramp_ch_s = x_r[CH_W-1:0];
    end
  endgenerate

  // Colour-bar pixel for the current bar index.
  always_comb begin
    bars_pix_s = {PW{1'b0}};
    for (int ch = 0; ch < NUM_CH; ch++) begin
      bars_pix_s[ch*CH_W +: CH_W] = {CH_W{bar_bit(bar_r, ch)}};
    end
  end

  // Push source select; in generator modes wr_en and din are ignored.
  always_comb begin
    push_req_s  = 1'b0;
    push_data_s = {PW{1'b0}};
    case (active_mode_r)
      MODE_EXT: begin
        push_req_s  = wr_en;
        push_data_s = din;
      end
      MODE_SOLID: begin
        push_req_s  = gen_push_s;
        push_data_s = pattern_color;
      end
      MODE_RAMP: begin
        push_req_s  = gen_push_s;
        push_data_s = {NUM_CH{ramp_ch_s}};
      end
      MODE_BARS: begin
        push_req_s  = gen_push_s;
        push_data_s = bars_pix_s;
      end
      default: begin
        push_req_s  = 1'b0;
        push_data_s = {PW{1'b0}};
      end
    endcase
  end

  // Mode latch: sampled only at line start so a line is never split between patterns.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_mode_r <= MODE_EXT;
    end else if (x_r == {XW{1'b0}}) begin
      active_mode_r <= mode;
    end else begin
      active_mode_r <= active_mode_r;
    end
  end

  // Line position and bar counters, advanced by generator pushes only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_r   <= {XW{1'b0}};
      bar_r <= 3'd0;
      run_r <= {RW{1'b0}};
    end else if (!gen_mode_s) begin
      x_r   <= {XW{1'b0}};
      bar_r <= 3'd0;
      run_r <= {RW{1'b0}};
    end else if (gen_push_s) begin
      if (x_r == X_LAST) begin
        x_r   <= {XW{1'b0}};
        bar_r <= 3'd0;
        run_r <= {RW{1'b0}};
      end else if (run_r == RUN_LAST) begin
        x_r   <= x_r + 1'b1;
        bar_r <= bar_r + 1'b1;
        run_r <= {RW{1'b0}};
      end else begin
        x_r   <= x_r + 1'b1;
        run_r <= run_r + 1'b1;
      end
    end
  end

  assign ovf_set_s = (active_mode_r == MODE_EXT) & wr_en & full_s;
  assign unf_set_s = rd_en & empty_s;

  // Sticky error flags; a new error outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= ovf_set_s | (overflow_r & ~clear_flags);
      underflow_r <= unf_set_s | (underflow_r & ~clear_flags);
    end
  end

  assign overflow  = overflow_r;
  assign underflow = underflow_r;
  assign full      = full_s;
  assign empty     = empty_s;

  sync_fifo_core #(
    .WIDTH    (PW),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LEVEL),
    .AE_LEVEL (AE_LEVEL)
  ) u_core (
    .clk          (clk),
    .rst          (rst),
    .wr_req       (push_req_s),
    .wr_data      (push_data_s),
    .rd_req       (rd_en),
    .rd_data      (pixel),
    .rd_valid     (pixel_valid),
    .full         (full_s),
    .empty        (empty_s),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .level        (level)
  );

endmodule

// File: tb/tb_pixel_stream_fifo.sv
// Self-checking bench: vector table, directed corner sequences and a randomized run against a queue model.
module tb_pixel_stream_fifo;

  localparam int DEPTH = 16;
  localparam int H     = 640;
  localparam int RUN   = H / 8;
  localparam logic [23:0] BAR_RGB [8] = '{24'hFFFFFF, 24'hFFFF00, 24'hFF00FF, 24'hFF0000,
                                          24'h00FFFF, 24'h00FF00, 24'h0000FF, 24'h000000};

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        gen_en;
  logic [23:0] pattern_color;
  logic        wr_en;
  logic [23:0] din;
  logic        rd_en;
  logic        clear_flags;
  logic [23:0] pixel;
  logic        pixel_valid, full, empty, almost_full, almost_empty;
  logic [4:0]  level;
  logic        overflow, underflow;

  always #5 clk = ~clk;

  pixel_stream_fifo #(
    .CH_W(8), .NUM_CH(3), .DEPTH(DEPTH), .AF_LEVEL(DEPTH-2), .AE_LEVEL(2), .H_ACTIVE(H)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .gen_en(gen_en), .pattern_color(pattern_color),
    .wr_en(wr_en), .din(din), .rd_en(rd_en), .clear_flags(clear_flags),
    .pixel(pixel), .pixel_valid(pixel_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .level(level),
    .overflow(overflow), .underflow(underflow)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of pushed pixels plus line position and latched mode.
  logic [23:0] mq[$];
  logic [23:0] m_pixel;
  logic        m_valid, m_ovf, m_unf;
  int          m_x;
  logic [1:0]  m_amode;
  logic [23:0] popped[$];

  typedef struct {
    logic        wr;
    logic [23:0] din;
    logic        rd;
    int          lvl;
    logic        full;
    logic        af;
    logic        ovf;
    logic        unf;
    logic        valid;
    logic [23:0] pix;
  } vec_t;
  vec_t tbl[34];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] gen_pixel(input logic [1:0] am, input int x);
    logic [7:0] b;
    b = 8'(x % 256);
    case (am)
      2'd1:    return pattern_color;
      2'd2:    return {b, b, b};
      2'd3:    return BAR_RGB[x / RUN];
      default: return din;
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pixel = 24'h0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    m_x = 0; m_amode = 2'd0;
  endtask

  task automatic model_step();
    int          lvl;
    bit          mfull, mempty, push, pop;
    logic [23:0] pv;
    logic [1:0]  next_am;
    lvl    = mq.size();
    mfull  = (lvl == DEPTH);
    mempty = (lvl == 0);
    if (m_amode == 2'd0) begin
      push = wr_en && !mfull;
      pv   = din;
    end else begin
      push = gen_en && !mfull;
      pv   = gen_pixel(m_amode, m_x);
    end
    pop = rd_en && !mempty;
    if (pop) begin
      m_pixel = mq.pop_front();
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    if (push) mq.push_back(pv);
    m_ovf = (m_amode == 2'd0 && wr_en && mfull) || (m_ovf && !clear_flags);
    m_unf = (rd_en && mempty) || (m_unf && !clear_flags);
    next_am = (m_x == 0) ? mode : m_amode;
    if (m_amode == 2'd0) m_x = 0;
    else if (push) m_x = (m_x + 1) % H;
    m_amode = next_am;
  endtask

  task automatic check_model();
    int lvl;
    lvl = mq.size();
    check("pixel", pixel, m_pixel);
    check("pixel_valid", pixel_valid, m_valid);
    check("level", level, lvl);
    check("full", full, lvl == DEPTH);
    check("empty", empty, lvl == 0);
    check("almost_full", almost_full, lvl >= DEPTH - 2);
    check("almost_empty", almost_empty, lvl <= 2);
    check("overflow", overflow, m_ovf);
    check("underflow", underflow, m_unf);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_model();
    if (pixel_valid) popped.push_back(pixel);
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; clear_flags = 1'b0; gen_en = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    mode = 2'd0;
    rst = 1'b0;
    model_reset();
    #2;
    check_model();
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  initial begin
    rst = 1'b0; mode = 2'd0; gen_en = 1'b0; pattern_color = 24'h0;
    wr_en = 1'b0; din = 24'h0; rd_en = 1'b0; clear_flags = 1'b0;
    model_reset();

    // Mode 0 fill / overflow / drain / underflow vectors.
    for (int i = 0; i < 34; i++) begin
      tbl[i].wr = 1'b0; tbl[i].din = 24'h0; tbl[i].rd = 1'b0;
      tbl[i].ovf = 1'b0; tbl[i].unf = 1'b0; tbl[i].valid = 1'b0; tbl[i].pix = 24'h0;
      if (i < 16) begin
        tbl[i].wr = 1'b1; tbl[i].din = 24'(i + 1); tbl[i].lvl = i + 1;
      end else if (i == 16) begin
        tbl[i].wr = 1'b1; tbl[i].din = 24'h11; tbl[i].lvl = 16; tbl[i].ovf = 1'b1;
      end else if (i < 33) begin
        tbl[i].rd = 1'b1; tbl[i].lvl = 32 - i; tbl[i].ovf = 1'b1;
        tbl[i].valid = 1'b1; tbl[i].pix = 24'(i - 16);
      end else begin
        tbl[i].rd = 1'b1; tbl[i].lvl = 0; tbl[i].ovf = 1'b1; tbl[i].unf = 1'b1;
        tbl[i].pix = 24'h10;
      end
      tbl[i].full = (tbl[i].lvl == DEPTH);
      tbl[i].af   = (tbl[i].lvl >= DEPTH - 2);
    end

    do_reset();
    for (int i = 0; i < 34; i++) begin
      wr_en = tbl[i].wr; din = tbl[i].din; rd_en = tbl[i].rd;
      cycle();
      check("tbl_level", level, tbl[i].lvl);
      check("tbl_full", full, tbl[i].full);
      check("tbl_almost_full", almost_full, tbl[i].af);
      check("tbl_overflow", overflow, tbl[i].ovf);
      check("tbl_underflow", underflow, tbl[i].unf);
      check("tbl_valid", pixel_valid, tbl[i].valid);
      check("tbl_pixel", pixel, tbl[i].pix);
    end
    idle();

    // Asynchronous reset mid-stream at level 5.
    do_reset();
    rd_en = 1'b1; cycle();
    rd_en = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      wr_en = 1'b1; din = 24'(i); cycle();
    end
    wr_en = 1'b0; rd_en = 1'b1; cycle();
    rd_en = 1'b0;
    check("pre_reset_level", level, 5);
    rst = 1'b0;
    #2;
    check("rst_pixel", pixel, 24'h0);
    check("rst_valid", pixel_valid, 1'b0);
    check("rst_level", level, 5'd0);
    check("rst_empty", empty, 1'b1);
    check("rst_almost_empty", almost_empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_almost_full", almost_full, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_underflow", underflow, 1'b0);
    model_reset();
    @(negedge clk); rst = 1'b1; #1;
    cycle();
    check("post_reset_level", level, 5'd0);

    // Simultaneous push and pop at level 8.
    do_reset();
    popped.delete();
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; din = 24'h100 + 24'(i); cycle();
    end
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; rd_en = 1'b1; din = 24'h200 + 24'(i); cycle();
      check("pushpop_level8", level, 5'd8);
    end
    wr_en = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    rd_en = 1'b0;
    check("pushpop_count", popped.size(), 14);
    if (popped.size() == 14) begin
      check("pushpop_first", popped[0], 24'h100);
      check("pushpop_order", popped[8], 24'h200);
      check("pushpop_last", popped[13], 24'h205);
    end

    // Simultaneous push and pop on empty, then the clear-flags race.
    do_reset();
    wr_en = 1'b1; rd_en = 1'b1; din = 24'hABCDEF; cycle();
    check("empty_pushpop_level", level, 5'd1);
    check("empty_pushpop_unf", underflow, 1'b1);
    check("empty_pushpop_valid", pixel_valid, 1'b0);
    wr_en = 1'b0; cycle();
    check("empty_pushpop_data", pixel, 24'hABCDEF);
    clear_flags = 1'b1; cycle();
    check("clear_race_unf", underflow, 1'b1);
    rd_en = 1'b0; cycle();
    check("clear_alone_unf", underflow, 1'b0);
    clear_flags = 1'b0;

    // Colour bars with continuous reads.
    do_reset();
    popped.delete();
    mode = 2'd3; gen_en = 1'b1; rd_en = 1'b1;
    for (int c = 0; c < 900 && popped.size() < 650; c++) cycle();
    check("bars_count", popped.size() >= 650, 1'b1);
    if (popped.size() >= 650) begin
      check("bars_px0", popped[0], 24'hFFFFFF);
      check("bars_px79", popped[79], 24'hFFFFFF);
      check("bars_px80", popped[80], 24'hFFFF00);
      check("bars_px159", popped[159], 24'hFFFF00);
      check("bars_px160", popped[160], 24'hFF00FF);
      check("bars_px560", popped[560], 24'h000000);
      check("bars_px639", popped[639], 24'h000000);
      check("bars_px640", popped[640], 24'hFFFFFF);
    end

    // Ramp, then a mode change requested mid-line.
    do_reset();
    popped.delete();
    pattern_color = 24'h123456;
    mode = 2'd2; gen_en = 1'b1; rd_en = 1'b1;
    for (int c = 0, sw = 0; c < 1500 && popped.size() < 700; c++) begin
      cycle();
      if (sw == 0 && m_x == 300) begin
        mode = 2'd1; sw = 1;
      end
    end
    check("ramp_count", popped.size() >= 700, 1'b1);
    if (popped.size() >= 700) begin
      for (int i = 0; i < 640; i += 37) begin
        logic [7:0] b;
        b = 8'(i);
        check("ramp_px", popped[i], {b, b, b});
      end
      check("ramp_px301", popped[301], 24'h2D2D2D);
      check("ramp_px639", popped[639], 24'h7F7F7F);
      for (int i = 641; i < 700; i += 11) check("solid_px", popped[i], 24'h123456);
    end

    // Randomized traffic against the model, three read-pressure phases.
    for (int ph = 0; ph < 3; ph++) begin
      do_reset();
      for (int c = 0; c < 3000; c++) begin
        if ($urandom_range(0, 149) == 0) mode = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 63) == 0) pattern_color = 24'($urandom);
        gen_en      = ($urandom_range(0, 3) != 0);
        wr_en       = ($urandom_range(0, 1) != 0);
        din         = 24'($urandom);
        rd_en       = ($urandom_range(0, 9) < 3 + 2 * ph);
        clear_flags = ($urandom_range(0, 15) == 0);
        cycle();
      end
    end

    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
